wb_trace_fifo: RTL and testbench

Commit-trace buffer sitting directly downstream of the pipeline's write-back stage. Captures each retired instruction's PC and instruction word, tags it with a sequence number, and buffers the records in a FIFO drained by a debug/trace consumer over a valid/ready handshake. Overflow drops new records rather than stalling the core and is reported through a sticky flag.

---
 rtl/arm_trace_pkg.sv | 13 +
 rtl/trace_ram.sv | 24 ++
 rtl/wb_trace_fifo.sv | 115 +++++++++++
 tb/tb_wb_trace_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_trace_pkg.sv
// rtl/arm_trace_pkg.sv - shared trace record type and constants for the commit-trace buffer
package arm_trace_pkg;

  localparam int TRACE_SEQ_W = 16;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [31:0]            pc;
    logic [31:0]            instr;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_rec_t;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - trace record register array, one synchronous write port, asynchronous read port
import arm_trace_pkg::*;

module trace_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  trace_rec_t        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output trace_rec_t        rdata
);

  trace_rec_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - write-back commit-trace FIFO with drop-on-overflow
// Optional saturating drop counter and drop_cnt port enabled by TRACE_DROP_CNT_EN.
import arm_trace_pkg::*;

module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = TRACE_SEQ_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic                     freeze,
  input  logic [31:0]              wb_pc,
  input  logic [31:0]              wb_instr,
  input  logic                     clear,
  output logic                     tr_valid,
  input  logic                     tr_ready,
  output logic [31:0]              tr_pc,
  output logic [31:0]              tr_instr,
  output logic [SEQ_W-1:0]         tr_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
`ifdef TRACE_DROP_CNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [SEQ_W-1:0]  seq_ctr;
  logic              ovf;
  logic              capture;
  logic              pop;
  logic              push;
  logic              drop;
  trace_rec_t        wr_rec;
  trace_rec_t        rd_rec;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign tr_valid = !empty;
  assign count    = cnt;
  assign overflow = ovf;

  assign capture = wb_valid && !freeze;
  assign pop     = tr_valid && tr_ready;
  // A pop frees the slot this very cycle, so a full buffer can still accept.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_comb begin
    wr_rec       = '0;
    wr_rec.pc    = wb_pc;
    wr_rec.instr = wb_instr;
    wr_rec.seq   = TRACE_SEQ_W'(seq_ctr);
  end

  trace_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push && !clear && !rst),
    .waddr (wr_ptr),
    .wdata (wr_rec),
    .raddr (rd_ptr),
    .rdata (rd_rec)
  );

  // The sequence counter survives clear so consumers can see a gap across it.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_ctr <= '0;
    end else if (capture) begin
      seq_ctr <= seq_ctr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (drop) ovf <= 1'b1;
    end
  end

`ifdef TRACE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != DROP_CNT_MAX) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

  assign tr_pc    = empty ? 32'h0 : rd_rec.pc;
  assign tr_instr = empty ? 32'h0 : rd_rec.instr;
  assign tr_seq   = empty ? '0 : SEQ_W'(rd_rec.seq);

endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb/tb_wb_trace_fifo.sv - self-checking bench for wb_trace_fifo with a queue-based reference model
// Drop-counter checks are compiled in when TRACE_DROP_CNT_EN is defined.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;
  localparam int SEQ_W = 16;

  logic              clk = 1'b0;
  logic              rst, wb_valid, freeze, clear, tr_ready;
  logic [31:0]       wb_pc, wb_instr;
  logic              tr_valid, full, empty, overflow;
  logic [31:0]       tr_pc, tr_instr;
  logic [SEQ_W-1:0]  tr_seq;
  logic [4:0]        count;
`ifdef TRACE_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  int passed = 0;
  int total  = 0;

  typedef struct { int unsigned pc; int unsigned instr; int unsigned seq; } rec_t;
  rec_t        mq[$];
  int unsigned m_seq;
  bit          m_ovf;
  int unsigned m_drop;

  always #5 clk = ~clk;

  wb_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .freeze(freeze),
    .wb_pc(wb_pc), .wb_instr(wb_instr), .clear(clear),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc),
    .tr_instr(tr_instr), .tr_seq(tr_seq), .count(count),
    .full(full), .empty(empty), .overflow(overflow)
`ifdef TRACE_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  // Reference model: advance by the rules, using the inputs present before the edge.
  task automatic model_step();
    bit cap;
    bit pop;
    cap = wb_valid && !freeze;
    pop = (mq.size() > 0) && tr_ready;
    if (rst) begin
      mq.delete(); m_seq = 0; m_ovf = 0; m_drop = 0;
    end else if (clear) begin
      mq.delete(); m_ovf = 0; m_drop = 0;
      if (cap) m_seq = (m_seq + 1) % 65536;
    end else begin
      if (pop) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) mq.push_back('{wb_pc, wb_instr, m_seq});
        else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
        m_seq = (m_seq + 1) % 65536;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; freeze = 0; clear = 0; tr_ready = 0; rst = 0;
    wb_pc = 0; wb_instr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic capture_n(input int n, input int unsigned base_pc);
    for (int i = 0; i < n; i++) begin
      wb_valid = 1; wb_pc = base_pc + 4 * i; wb_instr = $urandom;
      tick();
    end
    wb_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0;
    total++; if (tr_valid !== 1'b0) $display("FAIL reset_tr_valid got %0b want 0", tr_valid); else passed++;
    total++; if (tr_pc !== 32'h0) $display("FAIL reset_tr_pc got %h want 0", tr_pc); else passed++;
    total++; if (tr_instr !== 32'h0) $display("FAIL reset_tr_instr got %h want 0", tr_instr); else passed++;
    total++; if (tr_seq !== 16'h0) $display("FAIL reset_tr_seq got %0d want 0", tr_seq); else passed++;
    total++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got %0b want 0", full); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL reset_empty got %0b want 1", empty); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else passed++;
`ifdef TRACE_DROP_CNT_EN
    total++; if (drop_cnt !== 16'h0) $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); else passed++;
`endif
  endtask

  task automatic test_basic();
    capture_n(3, 32'h0);
    total++; if (count !== 5'd3) $display("FAIL basic_count got %0d want 3", count); else passed++;
    total++; if (tr_pc !== 32'h0) $display("FAIL basic_head_pc got %h want 0", tr_pc); else passed++;
    total++; if (tr_seq !== 16'd0) $display("FAIL basic_head_seq got %0d want 0", tr_seq); else passed++;
    tr_ready = 1;
    for (int i = 0; i < 3; i++) begin
      total++; if (tr_seq !== 16'(i)) $display("FAIL basic_drain_seq got %0d want %0d", tr_seq, i); else passed++;
      total++; if (tr_pc !== 32'(4 * i)) $display("FAIL basic_drain_pc got %h want %h", tr_pc, 4 * i); else passed++;
      tick();
    end
    tr_ready = 0;
    total++; if (empty !== 1'b1) $display("FAIL basic_empty_after got %0b want 1", empty); else passed++;
  endtask

  task automatic test_freeze();
    wb_valid = 1; freeze = 1; wb_pc = 32'hDEAD0000;
    for (int i = 0; i < 4; i++) tick();
    freeze = 0; wb_valid = 0;
    total++; if (count !== 5'd0) $display("FAIL freeze_count got %0d want 0", count); else passed++;
    capture_n(1, 32'h100);
    total++; if (tr_seq !== 16'd3) $display("FAIL freeze_seq_unchanged got %0d want 3", tr_seq); else passed++;
    tr_ready = 1; tick(); tr_ready = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    capture_n(DEPTH + 2, 32'h1000);
    total++; if (full !== 1'b1) $display("FAIL ovf_full got %0b want 1", full); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0b want 1", overflow); else passed++;
    total++; if (count !== 5'd16) $display("FAIL ovf_count got %0d want 16", count); else passed++;
`ifdef TRACE_DROP_CNT_EN
    total++; if (drop_cnt !== 16'd2) $display("FAIL ovf_drop_cnt got %0d want 2", drop_cnt); else passed++;
`endif
    tr_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      total++; if (tr_seq !== 16'(i)) $display("FAIL ovf_drain_seq got %0d want %0d", tr_seq, i); else passed++;
      tick();
    end
    tr_ready = 0;
    total++; if (empty !== 1'b1) $display("FAIL ovf_empty got %0b want 1", empty); else passed++;
    capture_n(1, 32'h2000);
    total++; if (tr_seq !== 16'd18) $display("FAIL ovf_gap_seq got %0d want 18", tr_seq); else passed++;
    tr_ready = 1; tick(); tr_ready = 0;
  endtask

  task automatic test_full_pushpop();
    do_reset();
    capture_n(DEPTH, 32'h3000);
    wb_valid = 1; wb_pc = 32'h3FFC; tr_ready = 1;
    tick();
    wb_valid = 0;
    total++; if (count !== 5'd16) $display("FAIL fpp_count got %0d want 16", count); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL fpp_overflow got %0b want 0", overflow); else passed++;
    total++; if (tr_seq !== 16'd1) $display("FAIL fpp_head_seq got %0d want 1", tr_seq); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      total++; if (tr_seq !== 16'(i + 1)) $display("FAIL fpp_drain_seq got %0d want %0d", tr_seq, i + 1); else passed++;
      tick();
    end
    tr_ready = 0;
  endtask

  task automatic test_clear();
    do_reset();
    capture_n(DEPTH + 1, 32'h4000);
    tr_ready = 1;
    for (int i = 0; i < 11; i++) tick();
    tr_ready = 0;
    total++; if (count !== 5'd5) $display("FAIL clr_pre_count got %0d want 5", count); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL clr_pre_overflow got %0b want 1", overflow); else passed++;
    clear = 1; wb_valid = 1; tr_ready = 1;
    tick();
    clear = 0; wb_valid = 0; tr_ready = 0;
    total++; if (count !== 5'd0) $display("FAIL clr_count got %0d want 0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL clr_empty got %0b want 1", empty); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL clr_overflow got %0b want 0", overflow); else passed++;
`ifdef TRACE_DROP_CNT_EN
    total++; if (drop_cnt !== 16'd0) $display("FAIL clr_drop_cnt got %0d want 0", drop_cnt); else passed++;
`endif
    capture_n(1, 32'h5000);
    total++; if (tr_seq !== 16'd18) $display("FAIL clr_seq_continues got %0d want 18", tr_seq); else passed++;
    tr_ready = 1; tick(); tr_ready = 0;
  endtask

  task automatic test_back_to_back();
    int unsigned exp;
    exp = 0;
    do_reset();
    tr_ready = 1;
    for (int i = 0; i < 44; i++) begin
      wb_valid = (i < 40); wb_pc = 32'(4 * i);
      total++; if (count > 5'd1) $display("FAIL b2b_count got %0d want <=1", count); else passed++;
      if (tr_valid) begin
        total++; if (tr_seq !== 16'(exp)) $display("FAIL b2b_seq got %0d want %0d", tr_seq, exp); else passed++;
        total++; if (tr_pc !== 32'(4 * exp)) $display("FAIL b2b_pc got %h want %h", tr_pc, 4 * exp); else passed++;
        exp++;
      end
      tick();
    end
    wb_valid = 0; tr_ready = 0;
    total++; if (exp != 40) $display("FAIL b2b_total_seen got %0d want 40", exp); else passed++;
  endtask

  task automatic test_random();
    rec_t h;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      wb_valid = ($urandom_range(0, 9) < 7);
      freeze   = ($urandom_range(0, 9) < 2);
      tr_ready = ($urandom_range(0, 9) < ((c / 100) % 2 ? 7 : 3));
      clear    = ($urandom_range(0, 99) < 2);
      rst      = ($urandom_range(0, 199) == 0);
      wb_pc    = $urandom; wb_instr = $urandom;
      h = '{0, 0, 0};
      if (mq.size() > 0) h = mq[0];
      total++; if (count !== 5'(mq.size())) $display("FAIL rnd_count got %0d want %0d", count, mq.size()); else passed++;
      total++; if (tr_valid !== (mq.size() > 0)) $display("FAIL rnd_tr_valid got %0b want %0b", tr_valid, mq.size() > 0); else passed++;
      total++; if (full !== (mq.size() == DEPTH)) $display("FAIL rnd_full got %0b want %0b", full, mq.size() == DEPTH); else passed++;
      total++; if (overflow !== m_ovf) $display("FAIL rnd_overflow got %0b want %0b", overflow, m_ovf); else passed++;
      total++; if (tr_pc !== h.pc || tr_instr !== h.instr || tr_seq !== 16'(h.seq))
        $display("FAIL rnd_head got %h/%h/%0d want %h/%h/%0d", tr_pc, tr_instr, tr_seq, h.pc, h.instr, h.seq);
      else passed++;
`ifdef TRACE_DROP_CNT_EN
      total++; if (drop_cnt !== 16'(m_drop)) $display("FAIL rnd_drop_cnt got %0d want %0d", drop_cnt, m_drop); else passed++;
`endif
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    mq.delete(); m_seq = 0; m_ovf = 0; m_drop = 0;
    test_reset();
    test_basic();
    test_freeze();
    test_overflow();
    test_full_pushpop();
    test_clear();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
